acq_trigger_engine: RTL

Parametrised acquisition/trigger engine in the `clklvds` domain: the next-generation capture path between the LVDS deserialisers and the event FIFO. It registers one beat of `NSAMP` de-interleaved samples per clock and arms from the `clk` domain. It fires on a rising, falling or external trigger and writes `length` beats to the event FIFO. It then holds until readout is acknowledged.

---
 rtl/acq_trigger_engine_pkg.sv | 36 +++
 rtl/acq_trigger_engine_sync_2ff.sv | 31 +++
 rtl/acq_trigger_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/acq_trigger_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acq_pkg
// Purpose  : Shared trigger types, FSM state encoding and beat packing helper
//            for the acquisition/trigger engine.
// Revision : 1.0 - initial release
// ============================================================================
package acq_pkg;

    // Trigger selection codes as seen on trig_type
    localparam logic [1:0] TRIG_NONE = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_EXT  = 2'd3;

    // Engine states; encoding is visible on state_o for debug
    typedef enum logic [2:0] {
        ACQ_IDLE    = 3'd0,
        ACQ_ARM1    = 3'd1,
        ACQ_ARM2    = 3'd2,
        ACQ_CAPTURE = 3'd3,
        ACQ_DONE    = 3'd4
    } acq_state_t;

    // Packs one lane as {strobe, sample}; the sample occupies the low sw bits.
    // Callers cast the result down to the real lane width.
    function automatic logic [31:0] pack_lane(input logic [31:0] sample,
                                              input logic [31:0] strobe,
                                              input int unsigned sw);
        logic [31:0] mask;
        mask = (32'd1 << sw) - 32'd1;
        return (strobe << sw) | (sample & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acq_trigger_engine_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Single-bit two-flop synchroniser into the clklvds domain.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clklvds,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two flops in series; only r_sync is allowed to fan out
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/acq_trigger_engine.sv
`default_nettype none
// ============================================================================
// Module   : acq_trigger_engine
// Purpose  : Registers NSAMP-sample beats, arms from the clk domain, fires on
//            rising/falling/external trigger, writes `length` beats to the
//            event FIFO and holds until readout is acknowledged.
// Options  : ACQ_PRETRIG_EN - PRETRIG-deep delay line ahead of the FIFO data.
// Revision : 1.0 - initial release
// ============================================================================
module acq_trigger_engine
    import acq_pkg::*;
#(
    parameter int NSAMP   = 40,
    parameter int SW      = 12,
    parameter int CW      = 2,
    parameter int LENW    = 16,
    parameter int PRETRIG = 4
) (
    input  logic                          clklvds,
    input  logic                          rstn,
    input  logic [NSAMP*SW-1:0]           samples_i,
    input  logic [NSAMP*CW-1:0]           clkstr_i,
    input  logic                          arm,
    input  logic                          readout_done,
    input  logic [1:0]                    trig_type,
    input  logic [$clog2(NSAMP)-1:0]      trig_ch,
    input  logic [SW-1:0]                 lowerthresh,
    input  logic [SW-1:0]                 upperthresh,
    input  logic [LENW-1:0]               length,
    input  logic                          ext_trig,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [NSAMP*(SW+CW)-1:0]      fifo_data,
    output logic [LENW-1:0]               triggercount,
    output logic [15:0]                   eventcount,
    output logic                          overflow,
    output logic [2:0]                    state_o
);

    localparam int LW = SW + CW;
    localparam int BW = NSAMP * LW;

    logic [NSAMP*SW-1:0]   r_samples;
    logic [NSAMP*CW-1:0]   r_clkstr;
    logic [BW-1:0]         w_packed;
    logic [BW-1:0]         w_beat;
    logic                  w_arm;
    logic                  w_rdone;
    acq_state_t            r_state;
    acq_state_t            w_next;
    logic [1:0]            r_trig_type;
    logic signed [SW-1:0]  w_lane;
    logic                  w_below;
    logic                  w_above;
    logic                  w_can_write;

    sync_2ff u_sync_arm (
        .clklvds (clklvds),
        .rstn    (rstn),
        .d       (arm),
        .q       (w_arm)
    );

    sync_2ff u_sync_rdone (
        .clklvds (clklvds),
        .rstn    (rstn),
        .d       (readout_done),
        .q       (w_rdone)
    );

    // Input register stage: trigger decisions and FIFO data both come from here
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            r_samples <= '0;
            r_clkstr  <= '0;
        end else begin
            r_samples <= samples_i;
            r_clkstr  <= clkstr_i;
        end
    end

    for (genvar k = 0; k < NSAMP; k++) begin : g_lane
        assign w_packed[k*LW +: LW] = LW'(pack_lane(32'(r_samples[k*SW +: SW]),
                                                    32'(r_clkstr[k*CW +: CW]),
                                                    SW));
    end

`ifdef ACQ_PRETRIG_EN
    logic [BW-1:0] r_dly [PRETRIG];

    // Free-running delay line so pre-trigger history is always available
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PRETRIG; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_packed;
            for (int i = 1; i < PRETRIG; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_beat = r_dly[PRETRIG-1];
`else
    assign w_beat = w_packed;
`endif

    assign w_lane      = r_samples[trig_ch*SW +: SW];
    assign w_below     = w_lane < $signed(lowerthresh);
    assign w_above     = w_lane > $signed(upperthresh);
    assign w_can_write = !fifo_full && (triggercount < length);

    // State register
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) r_state <= ACQ_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; losing arm only matters while waiting for a trigger
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACQ_IDLE: begin
                if (w_arm) begin
                    if (trig_type == TRIG_NONE || (trig_type == TRIG_EXT && ext_trig))
                        w_next = ACQ_CAPTURE;
                    else
                        w_next = ACQ_ARM1;
                end
            end
            ACQ_ARM1: begin
                if (!w_arm) w_next = ACQ_IDLE;
                else begin
                    case (r_trig_type)
                        TRIG_RISE: if (w_below)  w_next = ACQ_ARM2;
                        TRIG_FALL: if (w_above)  w_next = ACQ_ARM2;
                        TRIG_EXT:  if (ext_trig) w_next = ACQ_CAPTURE;
                        default:                 w_next = ACQ_IDLE;
                    endcase
                end
            end
            ACQ_ARM2: begin
                if (!w_arm) w_next = ACQ_IDLE;
                else begin
                    case (r_trig_type)
                        TRIG_RISE: if (w_above) w_next = ACQ_CAPTURE;
                        TRIG_FALL: if (w_below) w_next = ACQ_CAPTURE;
                        default:                w_next = ACQ_IDLE;
                    endcase
                end
            end
            ACQ_CAPTURE: if (!w_can_write) w_next = ACQ_DONE;
            ACQ_DONE:    if (w_rdone)      w_next = ACQ_IDLE;
            default:                       w_next = ACQ_IDLE;
        endcase
    end

    // Capture datapath, counters and sticky overflow
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            fifo_wr      <= 1'b0;
            fifo_data    <= '0;
            triggercount <= '0;
            eventcount   <= '0;
            overflow     <= 1'b0;
            r_trig_type  <= TRIG_NONE;
        end else begin
            fifo_wr <= 1'b0;
            case (r_state)
                ACQ_IDLE: begin
                    triggercount <= '0;
                    r_trig_type  <= trig_type;
                end
                ACQ_CAPTURE: begin
                    fifo_data <= w_beat;
                    if (w_can_write) begin
                        fifo_wr      <= 1'b1;
                        triggercount <= triggercount + 1'b1;
                    end else begin
                        // All-ones doubles as the event-ready flag polled from clk
                        triggercount <= '1;
                        eventcount   <= eventcount + 16'd1;
                        if (fifo_full && (triggercount < length)) overflow <= 1'b1;
                    end
                end
                ACQ_DONE: begin
                    if (w_rdone) triggercount <= '0;
                end
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire
